ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 Parameter ID_TO_EX_WD, default 142, width of the ID-to-EX bus.
REQ-002 Parameter EX_TO_MEM_WD, default 80, width of the EX-to-MEM bus.
REQ-003 clk  input  1  single clock, all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-low.
REQ-005 stall  input  6  pipeline stall vector; bit 2 holds the EX input register, bit 3 holds the EX output.
REQ-006 id_to_ex_bus  input  ID_TO_EX_WD  packed ID fields, listed high to low: pc[141:110], alu_op[109:105], src_a[104:73], src_b[72:41], rf_we[40], rf_waddr[39:35], mem_op[34:32], store_data[31:0].
REQ-007 ex_to_mem_bus  output  EX_TO_MEM_WD  fields: data_ram_readen[79:76], pc[75:44], data_ram_en[43], data_ram_wen[42:39], sel_rf_res[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
REQ-008 ex_to_id_bus  output  39  forwarding bus: is_load[38], rf_we[37], rf_waddr[36:32], ex_result[31:0].
REQ-009 data_sram_en / data_sram_wen / data_sram_addr / data_sram_wdata  output  1/4/32/32  data SRAM request.
REQ-010 stallreq_for_ex  output  1  asks the controller to stall stall[3:0] while a divide is in progress.

Function
REQ-011 Input register updates as follows.
- If rst=0, it loads zero.
- Else if stall[2]=1 and stall[3]=0, it loads zero (bubble).
- Else if stall[2]=0, it captures id_to_ex_bus.
- Otherwise it holds its value.
REQ-012 alu_op encodings: 0 NOP (result 0), 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed), 7 SLTU, 8 SLL, 9 SRL, 10 SRA, 11 LUI, 12 DIVU, 13 MFHI, 14 MFLO.
- All arithmetic is mod 2^32 with no overflow trap.
- Shifts use src_b[4:0] as the amount and shift src_a.
- LUI result is {src_b[15:0],16'h0}.
REQ-013 mem_op encodings: 0 none, 1 LW, 2 SW, 3 SB; for mem_op≠0 the address is src_a+src_b and ex_result equals that address.
REQ-014 LW: data_ram_en=1, wen=0000, readen=1111, sel_rf_res=1, is_load=1.
REQ-015 SW: wen=1111, wdata=store_data.
REQ-016 SB: wen=0001<<addr[1:0], wdata={4{store_data[7:0]}}.
REQ-017 No alignment check is made; for a misaligned SW the address is passed unmodified.
REQ-018 data_sram_en is 1 only when mem_op≠0 and stall[3]=0; when data_sram_en=0, data_sram_wen is 0000.
REQ-019 The data_sram_* outputs and both output buses are combinational from the input register and the HI/LO/divider state.
REQ-020 Divider FSM has three states: IDLE, BUSY, DONE.
- IDLE→BUSY when the input register holds DIVU; the dividend and divisor are latched and a 6-bit count is set to 0.
- BUSY runs one restoring radix-2 step per cycle and moves to DONE after the 32nd step.
- DONE→IDLE on the first cycle with stall[3]=0.
REQ-021 stallreq_for_ex is 1 in IDLE while DIVU is present and in BUSY; it is 0 in DONE.
- DIVU therefore occupies EX for exactly 34 cycles when nothing downstream stalls.
REQ-022 HI/LO update on the DONE→IDLE edge: LO←quotient, HI←remainder.
- If the divisor is 0: LO←32'hFFFF_FFFF and HI←dividend.
- DIVU has rf_we forced to 0.
REQ-023 MFHI/MFLO return HI/LO as already updated.
- A DIVU whose DONE→IDLE edge has occurred is visible to an MFLO in EX on the next cycle.
- No bypass from the divider exists.
REQ-024 While stallreq_for_ex=1, the controller asserts stall[3:0]; the MEM register then receives bubbles and the EX input register holds.

Reset
REQ-025 On rst=0 at a clock edge:
- Input register, HI, LO, divider operands and count are cleared, and the FSM goes to IDLE.
- Consequently every output bus is zero, data_sram_en=0 and stallreq_for_ex=0.
REQ-026 Reset asserted while BUSY abandons the divide with no HI/LO update.

Verification
REQ-027 ADD src_a=7FFFFFFF, src_b=1, rf_waddr=3, rf_we=1 -> ex_result=80000000, ex_to_id_bus={0,1,3,80000000}.
REQ-028 SB src_a=1000, src_b=3, store_data=000000A5 -> data_sram_addr=1003, wen=1000, wdata=A5A5A5A5, data_ram_en=1.
REQ-029 LW with stall[3]=1 -> data_sram_en=0, wen=0000; after the stall releases, en=1 and ex_to_mem_bus readen=1111, sel_rf_res=1.
REQ-030 DIVU 100/7, then MFLO and MFHI -> stallreq high for 33 cycles, LO=14, HI=2, MFLO result 14, MFHI result 2.
REQ-031 DIVU 5/0 -> LO=FFFFFFFF, HI=5.
REQ-032 rst=0 at BUSY step 10, then a new DIVU 9/3 -> HI/LO stay 0 through the reset, then LO=3, HI=0 after a full 34-cycle sequence.
REQ-033 stall[2]=1 with stall[3]=0 -> the next cycle's ex_to_mem_bus is all zero.

Source files
------------

// File: rtl/ex_stage_if.sv
// ID/EX/MEM-facing bundle of the execute stage: stall vector, ID input bus, MEM/ID output buses, data SRAM request.
// Latency: none; the interface is a set of wires.
// Backpressure: stall is driven by the pipeline controller, and stallreq_for_ex is returned to it.
interface ex_stage_if #(
    parameter int ID_TO_EX_WD  = 142,
    parameter int EX_TO_MEM_WD = 80
);
    logic [5:0]              stall;
    logic [ID_TO_EX_WD-1:0]  id_to_ex_bus;
    logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus;
    logic [38:0]             ex_to_id_bus;
    logic                    data_sram_en;
    logic [3:0]              data_sram_wen;
    logic [31:0]             data_sram_addr;
    logic [31:0]             data_sram_wdata;
    logic                    stallreq_for_ex;

    // Pipeline/controller side: drives stall and the ID bus, observes everything EX produces.
    modport master (
        output stall, id_to_ex_bus,
        input  ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );

    // Execute stage side.
    modport slave (
        input  stall, id_to_ex_bus,
        output ex_to_mem_bus, ex_to_id_bus, data_sram_en, data_sram_wen,
               data_sram_addr, data_sram_wdata, stallreq_for_ex
    );
endinterface

// File: rtl/ex_stage.sv
// Execute stage: ALU, data SRAM address/strobe generation, 32-step restoring DIVU into HI/LO.
// Latency: one input register, then combinational outputs; a DIVU occupies EX for 34 cycles.
// Backpressure: stall[2] holds (or bubbles) the input register, stall[3] blocks the SRAM request; stallreq_for_ex while dividing.
module ex_stage #(
    parameter int ID_TO_EX_WD  = 142,
    parameter int EX_TO_MEM_WD = 80
) (
    input  logic        clk,
    input  logic        rst,
    ex_stage_if.slave   ex_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } div_state_t;

    localparam logic [4:0] OP_ADD  = 5'd1;
    localparam logic [4:0] OP_SUB  = 5'd2;
    localparam logic [4:0] OP_AND  = 5'd3;
    localparam logic [4:0] OP_OR   = 5'd4;
    localparam logic [4:0] OP_XOR  = 5'd5;
    localparam logic [4:0] OP_SLT  = 5'd6;
    localparam logic [4:0] OP_SLTU = 5'd7;
    localparam logic [4:0] OP_SLL  = 5'd8;
    localparam logic [4:0] OP_SRL  = 5'd9;
    localparam logic [4:0] OP_SRA  = 5'd10;
    localparam logic [4:0] OP_LUI  = 5'd11;
    localparam logic [4:0] OP_DIVU = 5'd12;
    localparam logic [4:0] OP_MFHI = 5'd13;
    localparam logic [4:0] OP_MFLO = 5'd14;

    localparam logic [2:0] MEM_LW = 3'd1;
    localparam logic [2:0] MEM_SW = 3'd2;
    localparam logic [2:0] MEM_SB = 3'd3;

    logic [ID_TO_EX_WD-1:0] r_in;
    div_state_t             r_state;
    div_state_t             w_state_nxt;
    logic [31:0]            r_hi;
    logic [31:0]            r_lo;
    logic [31:0]            r_dividend;
    logic [31:0]            r_divisor;
    logic [31:0]            r_quo;
    logic [31:0]            r_rem;
    logic [5:0]             r_cnt;

    logic [31:0] w_pc;
    logic [4:0]  w_alu_op;
    logic [31:0] w_src_a;
    logic [31:0] w_src_b;
    logic        w_rf_we_in;
    logic [4:0]  w_rf_waddr;
    logic [2:0]  w_mem_op;
    logic [31:0] w_store_data;
    logic [4:0]  w_shamt;
    logic        w_is_divu;
    logic        w_stallreq;
    logic [32:0] w_trial;
    logic [32:0] w_sub;
    logic [31:0] w_alu_res;
    logic [31:0] w_addr;
    logic        w_mem_en;
    logic        w_is_load;
    logic [3:0]  w_wen;
    logic [3:0]  w_readen;
    logic [31:0] w_wdata;
    logic [31:0] w_ex_result;
    logic        w_rf_we;
    logic        w_unused_stall;

    assign w_pc         = r_in[141:110];
    assign w_alu_op     = r_in[109:105];
    assign w_src_a      = r_in[104:73];
    assign w_src_b      = r_in[72:41];
    assign w_rf_we_in   = r_in[40];
    assign w_rf_waddr   = r_in[39:35];
    assign w_mem_op     = r_in[34:32];
    assign w_store_data = r_in[31:0];
    assign w_shamt      = w_src_b[4:0];
    assign w_is_divu    = (w_alu_op == OP_DIVU);

    // Only the EX hold/flush bits matter here; the rest of the vector belongs to other stages.
    assign w_unused_stall = ^{ex_if.stall[5:4], ex_if.stall[1:0]};

    // Input register: reset clears, stall[2] without stall[3] inserts a bubble, stall[2] with stall[3] holds.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_in <= '0;
        end else if (ex_if.stall[2] && !ex_if.stall[3]) begin
            r_in <= '0;
        end else if (!ex_if.stall[2]) begin
            r_in <= ex_if.id_to_ex_bus;
        end
    end

    // Divider state register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Divider next state; the stall request covers the launch cycle and all 32 steps, but not DONE.
    always_comb begin
        w_state_nxt = r_state;
        w_stallreq  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_is_divu) begin
                    w_state_nxt = S_BUSY;
                    w_stallreq  = 1'b1;
                end
            end
            S_BUSY: begin
                w_stallreq = 1'b1;
                if (r_cnt == 6'd31) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (!ex_if.stall[3]) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // One restoring step: shift the next dividend bit into the partial remainder and try to subtract.
    // w_sub[32] is the borrow, because the trial value is always below twice the divisor.
    assign w_trial = {r_rem, r_quo[31]};
    assign w_sub   = w_trial - {1'b0, r_divisor};

    // Divider datapath and HI/LO; HI/LO only change when the finished result leaves EX.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hi       <= '0;
            r_lo       <= '0;
            r_dividend <= '0;
            r_divisor  <= '0;
            r_quo      <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_divu) begin
                        r_dividend <= w_src_a;
                        r_divisor  <= w_src_b;
                        r_quo      <= w_src_a;
                        r_rem      <= '0;
                        r_cnt      <= '0;
                    end
                end
                S_BUSY: begin
                    r_rem <= w_sub[32] ? w_trial[31:0] : w_sub[31:0];
                    r_quo <= {r_quo[30:0], ~w_sub[32]};
                    r_cnt <= r_cnt + 6'd1;
                end
                S_DONE: begin
                    if (!ex_if.stall[3]) begin
                        if (r_divisor == 32'd0) begin
                            r_lo <= 32'hFFFF_FFFF;
                            r_hi <= r_dividend;
                        end else begin
                            r_lo <= r_quo;
                            r_hi <= r_rem;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // ALU result; DIVU itself produces no register result and unknown opcodes yield zero.
    always_comb begin
        w_alu_res = '0;
        case (w_alu_op)
            OP_ADD:  w_alu_res = w_src_a + w_src_b;
            OP_SUB:  w_alu_res = w_src_a - w_src_b;
            OP_AND:  w_alu_res = w_src_a & w_src_b;
            OP_OR:   w_alu_res = w_src_a | w_src_b;
            OP_XOR:  w_alu_res = w_src_a ^ w_src_b;
            OP_SLT:  w_alu_res = {31'd0, ($signed(w_src_a) < $signed(w_src_b))};
            OP_SLTU: w_alu_res = {31'd0, (w_src_a < w_src_b)};
            OP_SLL:  w_alu_res = w_src_a << w_shamt;
            OP_SRL:  w_alu_res = w_src_a >> w_shamt;
            OP_SRA:  w_alu_res = $unsigned($signed(w_src_a) >>> w_shamt);
            OP_LUI:  w_alu_res = {w_src_b[15:0], 16'h0000};
            OP_MFHI: w_alu_res = r_hi;
            OP_MFLO: w_alu_res = r_lo;
            default: w_alu_res = '0;
        endcase
    end

    assign w_addr    = w_src_a + w_src_b;
    assign w_mem_en  = (w_mem_op != 3'd0);
    assign w_is_load = (w_mem_op == MEM_LW);

    // Byte strobes and write data; no alignment check, the address goes out as computed.
    always_comb begin
        w_wen    = 4'b0000;
        w_readen = 4'b0000;
        w_wdata  = w_store_data;
        case (w_mem_op)
            MEM_LW: w_readen = 4'b1111;
            MEM_SW: w_wen    = 4'b1111;
            MEM_SB: begin
                w_wen   = 4'b0001 << w_addr[1:0];
                w_wdata = {4{w_store_data[7:0]}};
            end
            default: ;
        endcase
    end

    assign w_ex_result = w_mem_en ? w_addr : w_alu_res;
    assign w_rf_we     = w_rf_we_in & ~w_is_divu;

    assign ex_if.data_sram_en    = w_mem_en & ~ex_if.stall[3];
    assign ex_if.data_sram_wen   = ex_if.data_sram_en ? w_wen : 4'b0000;
    assign ex_if.data_sram_addr  = w_addr;
    assign ex_if.data_sram_wdata = w_wdata;
    assign ex_if.stallreq_for_ex = w_stallreq;

    assign ex_if.ex_to_mem_bus = {w_readen, w_pc, w_mem_en, w_wen, w_is_load,
                                  w_rf_we, w_rf_waddr, w_ex_result};
    assign ex_if.ex_to_id_bus  = {w_is_load, w_rf_we, w_rf_waddr, w_ex_result};
endmodule

// File: tb/tb_ex_stage.sv
// Testbench for ex_stage: table-driven ALU/memory vectors through a scoreboard, plus stall, divide and reset sequences.
// Latency: results are checked 2 time units after the edge that loads the input register.
// Backpressure: the bench plays the controller, raising stall[3:0] whenever stallreq_for_ex is seen.
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.ID_TO_EX_WD(142), .EX_TO_MEM_WD(80)) ex_if ();

    ex_stage #(.ID_TO_EX_WD(142), .EX_TO_MEM_WD(80)) dut (
        .clk   (clk),
        .rst   (rst),
        .ex_if (ex_if)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        string       name;
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic        we;
        logic [4:0]  wa;
        logic [2:0]  mop;
        logic [31:0] sd;
        logic [31:0] res;
        logic [3:0]  wen;
        logic [31:0] wdata;
    } vec_t;

    typedef struct {
        string       name;
        logic [79:0] mem;
        logic [38:0] id;
        logic        en;
        logic [3:0]  wen;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        chk_dat;
    } exp_t;

    exp_t sb[$];
    vec_t vt[$];

    function automatic logic [141:0] pack(input logic [31:0] pc, input logic [4:0] op,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic we, input logic [4:0] wa,
                                          input logic [2:0] mop, input logic [31:0] sd);
        return {pc, op, a, b, we, wa, mop, sd};
    endfunction

    function automatic vec_t mkv(input string name, input logic [4:0] op, input logic [31:0] a,
                                 input logic [31:0] b, input logic we, input logic [4:0] wa,
                                 input logic [2:0] mop, input logic [31:0] sd, input logic [31:0] res,
                                 input logic [3:0] wen, input logic [31:0] wdata);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.we = we; v.wa = wa;
        v.mop = mop; v.sd = sd; v.res = res; v.wen = wen; v.wdata = wdata;
        return v;
    endfunction

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic sb_check();
        exp_t e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL scoreboard: got no expected entry, required one");
            return;
        end
        e = sb.pop_front();
        check({e.name, ".mem_bus"}, 80'(ex_if.ex_to_mem_bus), e.mem);
        check({e.name, ".id_bus"},  80'(ex_if.ex_to_id_bus),  80'(e.id));
        check({e.name, ".sram_en"}, 80'(ex_if.data_sram_en),  80'(e.en));
        check({e.name, ".sram_wen"}, 80'(ex_if.data_sram_wen), 80'(e.wen));
        if (e.chk_dat) begin
            check({e.name, ".sram_addr"},  80'(ex_if.data_sram_addr),  80'(e.addr));
            check({e.name, ".sram_wdata"}, 80'(ex_if.data_sram_wdata), 80'(e.wdata));
        end
    endtask

    // Issue a DIVU, act as the controller while stallreq is up, then read LO and HI back.
    task automatic run_divu(input string name, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_lo, input logic [31:0] exp_hi);
        int cnt;
        ex_if.stall        = 6'b000000;
        ex_if.id_to_ex_bus = pack(32'h0040_1000, 5'd12, a, b, 1'b1, 5'd4, 3'd0, 32'd0);
        tick();
        cnt = 0;
        while (ex_if.stallreq_for_ex === 1'b1 && cnt < 100) begin
            cnt++;
            ex_if.stall        = 6'b001111;
            ex_if.id_to_ex_bus = pack(32'h0040_1004, 5'd14, 32'd0, 32'd0, 1'b1, 5'd5, 3'd0, 32'd0);
            tick();
        end
        check({name, ".stallreq_cycles"}, 80'(cnt), 80'(33));
        ex_if.stall = 6'b000000;
        check({name, ".divu_rf_we"}, 80'(ex_if.ex_to_mem_bus[37]), 80'(1'b0));
        tick();
        check({name, ".mflo"}, 80'(ex_if.ex_to_mem_bus[31:0]), 80'(exp_lo));
        ex_if.id_to_ex_bus = pack(32'h0040_1008, 5'd13, 32'd0, 32'd0, 1'b1, 5'd6, 3'd0, 32'd0);
        tick();
        check({name, ".mfhi"}, 80'(ex_if.ex_to_mem_bus[31:0]), 80'(exp_hi));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        vec_t v;
        logic ld;

        // name, op, a, b, we, waddr, mem_op, store_data, result, wen, wdata
        vt.push_back(mkv("add_ovf", 5'd1, 32'h7FFF_FFFF, 32'h1, 1'b1, 5'd3, 3'd0, 32'd0, 32'h8000_0000, 4'h0, 32'd0));
        vt.push_back(mkv("sub_neg", 5'd2, 32'd5, 32'd7, 1'b1, 5'd4, 3'd0, 32'd0, 32'hFFFF_FFFE, 4'h0, 32'd0));
        vt.push_back(mkv("and", 5'd3, 32'hF0F0, 32'hFF00, 1'b1, 5'd5, 3'd0, 32'd0, 32'h0000_F000, 4'h0, 32'd0));
        vt.push_back(mkv("or", 5'd4, 32'hF0F0, 32'hFF00, 1'b1, 5'd6, 3'd0, 32'd0, 32'h0000_FFF0, 4'h0, 32'd0));
        vt.push_back(mkv("xor", 5'd5, 32'hF0F0, 32'hFF00, 1'b1, 5'd7, 3'd0, 32'd0, 32'h0000_0FF0, 4'h0, 32'd0));
        vt.push_back(mkv("slt_neg", 5'd6, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd8, 3'd0, 32'd0, 32'h1, 4'h0, 32'd0));
        vt.push_back(mkv("slt_pos", 5'd6, 32'd3, 32'hFFFF_FFFE, 1'b1, 5'd9, 3'd0, 32'd0, 32'h0, 4'h0, 32'd0));
        vt.push_back(mkv("sltu", 5'd7, 32'hFFFF_FFFF, 32'h1, 1'b1, 5'd10, 3'd0, 32'd0, 32'h0, 4'h0, 32'd0));
        vt.push_back(mkv("sll31", 5'd8, 32'h1, 32'h3F, 1'b1, 5'd11, 3'd0, 32'd0, 32'h8000_0000, 4'h0, 32'd0));
        vt.push_back(mkv("srl", 5'd9, 32'h8000_0000, 32'h4, 1'b1, 5'd12, 3'd0, 32'd0, 32'h0800_0000, 4'h0, 32'd0));
        vt.push_back(mkv("sra", 5'd10, 32'h8000_0000, 32'h4, 1'b1, 5'd13, 3'd0, 32'd0, 32'hF800_0000, 4'h0, 32'd0));
        vt.push_back(mkv("lui", 5'd11, 32'h0, 32'h1234_5678, 1'b1, 5'd14, 3'd0, 32'd0, 32'h5678_0000, 4'h0, 32'd0));
        vt.push_back(mkv("nop", 5'd0, 32'd5, 32'd6, 1'b0, 5'd0, 3'd0, 32'd0, 32'h0, 4'h0, 32'd0));
        vt.push_back(mkv("sb_off3", 5'd0, 32'h1000, 32'h3, 1'b0, 5'd0, 3'd3, 32'h0000_00A5, 32'h1003, 4'b1000, 32'hA5A5_A5A5));
        vt.push_back(mkv("sb_off0", 5'd0, 32'h2000, 32'h0, 1'b0, 5'd0, 3'd3, 32'h1234_5678, 32'h2000, 4'b0001, 32'h7878_7878));
        vt.push_back(mkv("sw_misal", 5'd0, 32'h2000, 32'h6, 1'b0, 5'd0, 3'd2, 32'hDEAD_BEEF, 32'h2006, 4'b1111, 32'hDEAD_BEEF));
        vt.push_back(mkv("lw", 5'd0, 32'h100, 32'h4, 1'b1, 5'd7, 3'd1, 32'd0, 32'h104, 4'b0000, 32'd0));

        // Reset: everything observable must be zero.
        rst = 1'b0;
        ex_if.stall = 6'b000000;
        ex_if.id_to_ex_bus = pack(32'h0040_0000, 5'd1, 32'd1, 32'd2, 1'b1, 5'd1, 3'd1, 32'd9);
        tick();
        tick();
        check("reset.mem_bus", 80'(ex_if.ex_to_mem_bus), 80'(0));
        check("reset.id_bus", 80'(ex_if.ex_to_id_bus), 80'(0));
        check("reset.sram_en", 80'(ex_if.data_sram_en), 80'(0));
        check("reset.stallreq", 80'(ex_if.stallreq_for_ex), 80'(0));
        rst = 1'b1;

        // Table-driven vectors through the scoreboard.
        for (int i = 0; i < vt.size(); i++) begin
            v  = vt[i];
            ld = (v.mop == 3'd1);
            e.name    = v.name;
            e.mem     = {(ld ? 4'hF : 4'h0), 32'h0040_0000 + 32'(i * 4), (v.mop != 3'd0),
                         v.wen, ld, v.we, v.wa, v.res};
            e.id      = {ld, v.we, v.wa, v.res};
            e.en      = (v.mop != 3'd0);
            e.wen     = v.wen;
            e.addr    = v.res;
            e.wdata   = v.wdata;
            e.chk_dat = (v.mop != 3'd0);
            ex_if.id_to_ex_bus = pack(32'h0040_0000 + 32'(i * 4), v.op, v.a, v.b, v.we, v.wa, v.mop, v.sd);
            sb.push_back(e);
            tick();
            sb_check();
        end

        // LW held by stall[3]: no SRAM request until the stall releases.
        ex_if.stall = 6'b000000;
        ex_if.id_to_ex_bus = pack(32'h0040_0100, 5'd0, 32'h100, 32'h8, 1'b1, 5'd9, 3'd1, 32'd0);
        tick();
        ex_if.stall = 6'b001111;
        #1;
        check("lw_stall.sram_en", 80'(ex_if.data_sram_en), 80'(0));
        check("lw_stall.sram_wen", 80'(ex_if.data_sram_wen), 80'(0));
        tick();
        check("lw_held.sram_en", 80'(ex_if.data_sram_en), 80'(0));
        ex_if.stall = 6'b000000;
        #1;
        check("lw_release.sram_en", 80'(ex_if.data_sram_en), 80'(1));
        check("lw_release.readen", 80'(ex_if.ex_to_mem_bus[79:76]), 80'(4'hF));
        check("lw_release.sel_rf_res", 80'(ex_if.ex_to_mem_bus[38]), 80'(1));
        check("lw_release.addr", 80'(ex_if.data_sram_addr), 80'(32'h108));

        // SW under stall[3]: the write strobes must stay off.
        ex_if.id_to_ex_bus = pack(32'h0040_0104, 5'd0, 32'h200, 32'h0, 1'b0, 5'd0, 3'd2, 32'h1111_2222);
        tick();
        ex_if.stall = 6'b001111;
        #1;
        check("sw_stall.sram_wen", 80'(ex_if.data_sram_wen), 80'(0));
        ex_if.stall = 6'b000000;
        #1;
        check("sw_release.sram_wen", 80'(ex_if.data_sram_wen), 80'(4'hF));

        // Bubble: stall[2] without stall[3] flushes the input register.
        ex_if.id_to_ex_bus = pack(32'h0040_0108, 5'd1, 32'd1, 32'd2, 1'b1, 5'd2, 3'd0, 32'd0);
        tick();
        check("bubble_pre.result", 80'(ex_if.ex_to_mem_bus[31:0]), 80'(32'd3));
        ex_if.stall = 6'b000100;
        tick();
        check("bubble.mem_bus", 80'(ex_if.ex_to_mem_bus), 80'(0));
        check("bubble.id_bus", 80'(ex_if.ex_to_id_bus), 80'(0));
        ex_if.stall = 6'b000000;

        // Divides.
        run_divu("divu_100_7", 32'd100, 32'd7, 32'd14, 32'd2);
        run_divu("divu_5_0", 32'd5, 32'd0, 32'hFFFF_FFFF, 32'd5);

        // Reset in the middle of a divide: abandoned, HI/LO cleared and not updated.
        ex_if.stall = 6'b000000;
        ex_if.id_to_ex_bus = pack(32'h0040_2000, 5'd12, 32'd100, 32'd7, 1'b1, 5'd4, 3'd0, 32'd0);
        tick();
        ex_if.stall = 6'b001111;
        repeat (11) tick();
        check("divrst.busy_stallreq", 80'(ex_if.stallreq_for_ex), 80'(1));
        rst = 1'b0;
        ex_if.stall = 6'b000000;
        ex_if.id_to_ex_bus = '0;
        tick();
        check("divrst.stallreq", 80'(ex_if.stallreq_for_ex), 80'(0));
        check("divrst.mem_bus", 80'(ex_if.ex_to_mem_bus), 80'(0));
        rst = 1'b1;
        ex_if.id_to_ex_bus = pack(32'h0040_2004, 5'd14, 32'd0, 32'd0, 1'b1, 5'd5, 3'd0, 32'd0);
        tick();
        check("divrst.lo", 80'(ex_if.ex_to_mem_bus[31:0]), 80'(0));
        ex_if.id_to_ex_bus = pack(32'h0040_2008, 5'd13, 32'd0, 32'd0, 1'b1, 5'd6, 3'd0, 32'd0);
        tick();
        check("divrst.hi", 80'(ex_if.ex_to_mem_bus[31:0]), 80'(0));
        tick();
        check("divrst.hi_stays", 80'(ex_if.ex_to_mem_bus[31:0]), 80'(0));
        run_divu("divu_9_3", 32'd9, 32'd3, 32'd3, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
